// File: rtl/ddr_train_pkg.sv
// Shared types and helpers for the DDR PHY training sequencers.
// Honours DDR_DQSW_TRAIN_BACKOFF_EN (adds the BACKOFF state).
package ddr_train_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_SETTLE,
        ST_SAMPLE,
        ST_STEP,
`ifdef DDR_DQSW_TRAIN_BACKOFF_EN
        ST_BACKOFF,
`endif
        ST_NEXT,
        ST_FINISH
    } train_state_e;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    // All-ones tap value for a counter of width w (w < 32).
    function automatic logic [31:0] TAP_ALL_ONES(input int unsigned w);
        logic [63:0] ones;
        ones = (64'd1 << w) - 64'd1;
        return 32'(ones);
    endfunction

endpackage

// File: rtl/ddr_dqsw_train_ctrl_if.sv
// Training-sequencer bus: START/DONE handshake, results and per-lane IOD controls.
interface ddr_dqsw_train_ctrl_if #(
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned TAP_W     = 8
);
    logic                         START;
    logic                         BUSY;
    logic                         DONE;
    logic [NUM_LANES-1:0]         ERR_MASK;
    logic [NUM_LANES*TAP_W-1:0]   TAP_RESULT;
    logic [NUM_LANES-1:0]         DELAY_LINE_LOAD;
    logic [NUM_LANES-1:0]         DELAY_LINE_MOVE;
    logic [NUM_LANES-1:0]         DELAY_LINE_DIRECTION;
    logic [NUM_LANES-1:0]         EYE_MONITOR_CLEAR_FLAGS;
    logic [NUM_LANES-1:0]         EYE_MONITOR_EARLY;
    logic [NUM_LANES-1:0]         EYE_MONITOR_LATE;
    logic [NUM_LANES-1:0]         DELAY_LINE_OUT_OF_RANGE;

    // Trainer side
    modport master (
        input  START, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE,
        output BUSY, DONE, ERR_MASK, TAP_RESULT,
        output DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS
    );

    // Training state machine / IOD side
    modport slave (
        output START, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE,
        input  BUSY, DONE, ERR_MASK, TAP_RESULT,
        input  DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS
    );
endinterface

// File: rtl/ddr_train_settle_cnt.sv
// Loadable saturating down-counter for settle and pulse-gap timing.
module ddr_train_settle_cnt #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_c_o
);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_c_o = (cnt_q == '0);
endmodule

// File: rtl/ddr_dqsw_train_ctrl.sv
// Multi-lane DQSW delay sweep: finds each lane's LATE->EARLY edge, one lane at a time.
// Optional DDR_DQSW_TRAIN_BACKOFF_EN steps back BACKOFF_TAPS after the edge.
module ddr_dqsw_train_ctrl
    import ddr_train_pkg::*;
#(
    parameter int unsigned NUM_LANES     = 2,
    parameter int unsigned TAP_W         = 8,
    parameter int unsigned MAX_TAPS      = 128,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned BACKOFF_TAPS  = 2
) (
    input  logic                  FAB_CLK,
    input  logic                  RESET_N,
    ddr_dqsw_train_ctrl_if.master bus
);
    localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [TAP_W-1:0] TAP_ONES  = TAP_W'(TAP_ALL_ONES(TAP_W));
    localparam logic [TAP_W-1:0] TAP_LIMIT = TAP_W'(MAX_TAPS);

    if (MAX_TAPS > (2**TAP_W) - 1) begin : g_chk_max
        $error("MAX_TAPS does not fit the tap counter");
    end
    if (SETTLE_CYCLES < 1) begin : g_chk_settle
        $error("SETTLE_CYCLES must be at least 1");
    end
    if (BACKOFF_TAPS > MAX_TAPS) begin : g_chk_backoff
        $error("BACKOFF_TAPS exceeds MAX_TAPS");
    end

    train_state_e               state_q, state_d;
    logic [LANE_W-1:0]          lane_q, lane_d;
    logic [TAP_W-1:0]           tap_q, tap_d;
    logic                       seen_late_q, seen_late_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [NUM_LANES-1:0]       err_q, err_d;
    logic [NUM_LANES*TAP_W-1:0] result_q, result_d;
    logic [NUM_LANES-1:0]       load_q, load_d;
    logic [NUM_LANES-1:0]       move_q, move_d;
    logic [NUM_LANES-1:0]       clr_q, clr_d;
    logic                       dir_q, dir_d;
    logic                       settle_done_c;
    logic                       early_c, late_c, oor_c;
`ifdef DDR_DQSW_TRAIN_BACKOFF_EN
    logic [TAP_W-1:0]           bo_left_q, bo_left_d;
    logic                       gap_q, gap_d;
    logic [TAP_W-1:0]           bo_n_c;

    // Back-off never steps below tap 0
    assign bo_n_c = (tap_q < TAP_W'(BACKOFF_TAPS)) ? tap_q : TAP_W'(BACKOFF_TAPS);
`endif

    assign early_c = bus.EYE_MONITOR_EARLY[lane_q];
    assign late_c  = bus.EYE_MONITOR_LATE[lane_q];
    assign oor_c   = bus.DELAY_LINE_OUT_OF_RANGE[lane_q];

    ddr_train_settle_cnt #(.CNT_W(CNT_W)) u_settle (
        .clk        (FAB_CLK),
        .rst_n      (RESET_N),
        .load_i     (state_q == ST_CLEAR),
        .load_val_i (CNT_W'(SETTLE_CYCLES - 1)),
        .dec_i      (state_q == ST_SETTLE),
        .zero_c_o   (settle_done_c)
    );

    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            lane_q      <= '0;
            tap_q       <= '0;
            seen_late_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= '0;
            result_q    <= '0;
            load_q      <= '0;
            move_q      <= '0;
            clr_q       <= '0;
            dir_q       <= 1'b0;
`ifdef DDR_DQSW_TRAIN_BACKOFF_EN
            bo_left_q   <= '0;
            gap_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            tap_q       <= tap_d;
            seen_late_q <= seen_late_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            result_q    <= result_d;
            load_q      <= load_d;
            move_q      <= move_d;
            clr_q       <= clr_d;
            dir_q       <= dir_d;
`ifdef DDR_DQSW_TRAIN_BACKOFF_EN
            bo_left_q   <= bo_left_d;
            gap_q       <= gap_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        tap_d       = tap_q;
        seen_late_d = seen_late_q;
        err_d       = err_q;
        result_d    = result_q;
        dir_d       = dir_q;
`ifdef DDR_DQSW_TRAIN_BACKOFF_EN
        bo_left_d   = bo_left_q;
        gap_d       = gap_q;
`endif
        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (bus.START) begin
                    state_d = ST_LOAD;
                    lane_d  = '0;
                    err_d   = '0;
                end
            end
            ST_LOAD: begin
                tap_d       = '0;
                seen_late_d = 1'b0;
                state_d     = ST_CLEAR;
            end
            ST_CLEAR:  state_d = ST_SETTLE;
            ST_SETTLE: if (settle_done_c) state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                if (oor_c || (tap_q == TAP_LIMIT)) begin
                    err_d[lane_q]                          = 1'b1;
                    result_d[int'(lane_q)*TAP_W +: TAP_W] = TAP_ONES;
                    state_d                                = ST_NEXT;
                end else if (late_c && !early_c) begin
                    seen_late_d = 1'b1;
                    state_d     = ST_STEP;
                end else if (early_c && !late_c && seen_late_q) begin
`ifdef DDR_DQSW_TRAIN_BACKOFF_EN
                    result_d[int'(lane_q)*TAP_W +: TAP_W] = tap_q - bo_n_c;
                    bo_left_d = bo_n_c;
                    gap_d     = 1'b0;
                    state_d   = (bo_n_c == '0) ? ST_NEXT : ST_BACKOFF;
`else
                    result_d[int'(lane_q)*TAP_W +: TAP_W] = tap_q;
                    state_d = ST_NEXT;
`endif
                end else begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (tap_q != TAP_ONES) tap_d = tap_q + TAP_W'(1);
                state_d = ST_CLEAR;
            end
`ifdef DDR_DQSW_TRAIN_BACKOFF_EN
            // Alternate pulse and gap cycles until all back-off steps are issued
            ST_BACKOFF: begin
                if (!gap_q) begin
                    bo_left_d = bo_left_q - TAP_W'(1);
                    gap_d     = 1'b1;
                end else if (bo_left_q == '0) begin
                    state_d = ST_NEXT;
                end else begin
                    gap_d = 1'b0;
                end
            end
`endif
            ST_NEXT: begin
                if (lane_q == LANE_W'(NUM_LANES - 1)) begin
                    state_d = ST_FINISH;
                end else begin
                    lane_d  = lane_q + LANE_W'(1);
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered outputs mirror the state being entered
        busy_d = (state_d != ST_IDLE) && (state_d != ST_FINISH);
        done_d = (state_d == ST_FINISH);
        load_d = (state_d == ST_LOAD)  ? (NUM_LANES'(1) << lane_d) : '0;
        clr_d  = (state_d == ST_CLEAR) ? (NUM_LANES'(1) << lane_d) : '0;
        move_d = (state_d == ST_STEP)  ? (NUM_LANES'(1) << lane_d) : '0;
        if (state_d == ST_STEP) dir_d = DIR_INC;
`ifdef DDR_DQSW_TRAIN_BACKOFF_EN
        if (state_d == ST_BACKOFF) begin
            dir_d = DIR_DEC;
            if (!gap_d) move_d = NUM_LANES'(1) << lane_d;
        end
`endif
    end

    assign bus.BUSY                    = busy_q;
    assign bus.DONE                    = done_q;
    assign bus.ERR_MASK                = err_q;
    assign bus.TAP_RESULT              = result_q;
    assign bus.DELAY_LINE_LOAD         = load_q;
    assign bus.DELAY_LINE_MOVE         = move_q;
    assign bus.EYE_MONITOR_CLEAR_FLAGS = clr_q;
    assign bus.DELAY_LINE_DIRECTION    = {NUM_LANES{dir_q}};
endmodule
